// File: rtl/fsm_ck11_pkg.sv
// Shared types for the "11" transmitter and its detector mirror.
// Holds the transmitter states, the detector encoding and the hit-counter helper.
package fsm_ck11_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } tx_state_t;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } det_state_t;

  localparam int HIT_W = 8;

  function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] v);
    return (v == {HIT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fsm_ck11_mirror.sv
// Mirror of the "11" detector: tracks the transmitted stream and counts cycles
// in which the detector would assert, saturating at 255.
module fsm_ck11_mirror
  import fsm_ck11_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             t,
  output logic [HIT_W-1:0] hit_cnt
);

  det_state_t       det_q, det_nx;
  logic [HIT_W-1:0] hit_nx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      det_q   <= S0;
      hit_cnt <= '0;
    end else begin
      det_q   <= det_nx;
      hit_cnt <= hit_nx;
    end
  end

  // Clearing on acceptance drops history, so a "11" across two words is not counted.
  always_comb begin
    det_nx = det_q;
    hit_nx = hit_cnt;
    if (clr) begin
      det_nx = S0;
      hit_nx = '0;
    end else if (en) begin
      case (det_q)
        S0:      det_nx = t ? S1 : S0;
        S1, S2:  det_nx = t ? S2 : S0;
        default: det_nx = S0;
      endcase
      if (det_nx == S2) hit_nx = sat_inc(hit_cnt);
    end
  end

endmodule

// File: rtl/fsm_ck11_tx.sv
// Serial MSB-first word transmitter with repeat count and one-cycle zero gap.
// Defining FSM_CK11_TX_CHK_EN adds the detector mirror and the hit_cnt port.
//
// state | meaning
// IDLE  | waiting for load, T=0, ready=1
// SHIFT | driving word bits MSB-first on T
// GAP   | one forced-zero cycle between repetitions
module fsm_ck11_tx
  import fsm_ck11_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     din,
  input  logic [CNT_W-1:0] rep,
  input  logic             load,
  output logic             ready,
  output logic             T,
  output logic             busy,
  output logic             done
`ifdef FSM_CK11_TX_CHK_EN
  ,
  output logic [HIT_W-1:0] hit_cnt
`endif
);

  localparam int BW = $clog2(W);

  tx_state_t        state_q, state_nx;
  logic [W-1:0]     sr_q, sr_nx;
  logic [W-1:0]     word_q, word_nx;
  logic [BW-1:0]    bit_q, bit_nx;
  logic [CNT_W-1:0] rep_q, rep_nx;
  logic             t_nx, done_nx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      word_q  <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
      T       <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_nx;
      sr_q    <= sr_nx;
      word_q  <= word_nx;
      bit_q   <= bit_nx;
      rep_q   <= rep_nx;
      T       <= t_nx;
      ready   <= (state_nx == IDLE);
      busy    <= (state_nx != IDLE);
      done    <= done_nx;
    end
  end

  // T is registered, so the bit loaded into t_nx is the one visible next cycle;
  // sr_q always holds the bits still to be sent after the one on T.
  always_comb begin
    state_nx = state_q;
    sr_nx    = sr_q;
    word_nx  = word_q;
    bit_nx   = bit_q;
    rep_nx   = rep_q;
    t_nx     = 1'b0;
    done_nx  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_nx = SHIFT;
          word_nx  = din;
          sr_nx    = din << 1;
          t_nx     = din[W-1];
          bit_nx   = BW'(W - 1);
          rep_nx   = rep;
        end
      end
      SHIFT: begin
        if (bit_q != '0) begin
          t_nx   = sr_q[W-1];
          sr_nx  = sr_q << 1;
          bit_nx = bit_q - 1'b1;
        end else if (rep_q != '0) begin
          state_nx = GAP;
          rep_nx   = rep_q - 1'b1;
          sr_nx    = word_q;
        end else begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      GAP: begin
        state_nx = SHIFT;
        t_nx     = sr_q[W-1];
        sr_nx    = sr_q << 1;
        bit_nx   = BW'(W - 1);
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef FSM_CK11_TX_CHK_EN
  logic accept;
  assign accept = ready & load;

  fsm_ck11_mirror u_mirror (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (busy),
    .t       (T),
    .hit_cnt (hit_cnt)
  );
`endif

endmodule

// File: tb/tb_fsm_ck11_tx.sv
// Self-checking bench for fsm_ck11_tx: expected T streams, done timing and hit
// counts come from a word/repeat model built as a queue of bits.
module tb_fsm_ck11_tx;

  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [W-1:0]     din = '0;
  logic [CNT_W-1:0] rep = '0;
  logic             load = 1'b0;
  logic             ready, T, busy, done;
`ifdef FSM_CK11_TX_CHK_EN
  logic [7:0]       hit_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fsm_ck11_tx #(.W(W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .rep   (rep),
    .load  (load),
    .ready (ready),
    .T     (T),
    .busy  (busy),
    .done  (done)
`ifdef FSM_CK11_TX_CHK_EN
    ,
    .hit_cnt (hit_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for ready, then presents one request; returns in cycle k+1.
  task automatic send(input logic [W-1:0] word, input int nrep, input string name);
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    n_assert++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_wait: ready=%b never rose, required 1", name, ready);
    end
    din  = word;
    rep  = CNT_W'(nrep);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Checks the whole transmitted stream starting in cycle k+1, then the done cycle.
  // junk_at >= 0 pulses a load with din=0 while busy, sampled at the end of that cycle.
  task automatic check_stream(input logic [W-1:0] word, input int nrep,
                              input string name, input int junk_at);
    bit q[$];
    int exp_hits = 0;
    for (int r = 0; r <= nrep; r++) begin
      for (int b = W - 1; b >= 0; b--) q.push_back(word[b]);
      if (r < nrep) q.push_back(1'b0);
    end
    for (int i = 1; i < q.size(); i++)
      if (q[i] && q[i-1] && exp_hits < 255) exp_hits++;

    for (int j = 0; j < q.size(); j++) begin
      n_assert++;
      if (T !== q[j] || busy !== 1'b1 || ready !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s bit%0d: T=%b busy=%b ready=%b done=%b, required T=%b busy=1 ready=0 done=0",
                 name, j, T, busy, ready, done, q[j]);
      end
      if (junk_at >= 0 && j == junk_at) begin
        load = 1'b1;
        din  = '0;
        rep  = CNT_W'($urandom_range(0, 15));
      end else if (junk_at >= 0 && j == junk_at + 1) begin
        load = 1'b0;
      end
      tick();
    end
    n_assert++;
    if (done !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || T !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_cycle: done=%b ready=%b busy=%b T=%b, required 1 1 0 0",
               name, done, ready, busy, T);
    end
`ifdef FSM_CK11_TX_CHK_EN
    n_assert++;
    if (hit_cnt !== 8'(exp_hits)) begin
      n_fail++;
      $display("FAIL %s hit_cnt: got %0d, required %0d", name, hit_cnt, exp_hits);
    end
`endif
  endtask

  task automatic check_done_cleared(input string name);
    tick();
    n_assert++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_pulse: done=%b one cycle later, required 0", name, done);
    end
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    load = 1'b1;
    din  = 8'hFF;
    tick();
    tick();
    n_assert++;
    if (T !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals: T=%b ready=%b busy=%b done=%b, required 0 1 0 0",
               T, ready, busy, done);
    end
`ifdef FSM_CK11_TX_CHK_EN
    n_assert++;
    if (hit_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_hit: got %0d, required 0", hit_cnt);
    end
`endif
    load = 1'b0;
    rst  = 1'b1;
    tick();
    n_assert++;
    if (busy !== 1'b0 || ready !== 1'b1 || T !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_accept: busy=%b ready=%b T=%b, required 0 1 0", busy, ready, T);
    end
  endtask

  task automatic test_single();
    send(8'hA5, 0, "a5");
    check_stream(8'hA5, 0, "a5", -1);
    check_done_cleared("a5");
  endtask

  task automatic test_repeat();
    send(8'hFF, 2, "ff_rep2");
    check_stream(8'hFF, 2, "ff_rep2", -1);
    check_done_cleared("ff_rep2");
    send(8'hFF, 15, "ff_rep15");
    check_stream(8'hFF, 15, "ff_rep15", -1);
  endtask

  task automatic test_load_ignored();
    tick();
    send(8'h6E, 0, "6e_junk");
    check_stream(8'h6E, 0, "6e_junk", 1);
    load = 1'b0;
  endtask

  task automatic test_abort();
    tick();
    send(8'hFF, 0, "abort");
    for (int j = 0; j < 4; j++) begin
      n_assert++;
      if (T !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_pre%0d: T=%b busy=%b, required 1 1", j, T, busy);
      end
      if (j == 3) rst = 1'b0;
      tick();
    end
    n_assert++;
    if (T !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: T=%b ready=%b busy=%b done=%b, required 0 1 0 0",
               T, ready, busy, done);
    end
    rst = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      n_assert++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_after%0d: done=%b busy=%b, required 0 0", j, done, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    send(8'h81, 0, "b2b");
    load = 1'b1;
    din  = 8'h80;
    rep  = '0;
    check_stream(8'h81, 0, "b2b_w1", -1);
    tick();
    load = 1'b0;
    check_stream(8'h80, 0, "b2b_w2", -1);
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    int r;
    for (int n = 0; n < 10; n++) begin
      w = W'($urandom);
      r = $urandom_range(0, 3);
      repeat ($urandom_range(0, 2)) tick();
      send(w, r, $sformatf("rnd%0d", n));
      check_stream(w, r, $sformatf("rnd%0d", n), -1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_load_ignored();
    test_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
